// File: rtl/me_control.sv
// me_control: sequences a 16-PE full-search motion estimator over a 16x16 block.
module me_control (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        CompStart,
  output logic [15:0] PEready,
  output logic [3:0]  vectorX,
  output logic [3:0]  vectorY,
  output logic [15:0] newDist,
  output logic [7:0]  AddressR
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state;
  logic [12:0] count;
  logic        run, ready;
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state == IDLE ? (start ? RUN : IDLE) :
               state == RUN  ? (count == 13'd4111 ? DONE : RUN) : IDLE;
      count <= (state == RUN && count != 13'd4111) ? count + 13'd1 : '0;
    end
  assign run       = state == RUN;
  // a PE reports its previous row while the next row restarts, so row 0 never reports
  assign ready     = run && count[12:8] != 5'd0 && count[7:4] == 4'd0;
  assign busy      = run;
  assign CompStart = run;
  assign done      = state == DONE;
  assign newDist   = (run && !count[12] && count[7:4] == 4'd0) ? 16'd1 << count[3:0] : '0;
  assign PEready   = ready ? 16'd1 << count[3:0] : '0;
  assign vectorX   = ready ? count[3:0] : '0;
  assign vectorY   = ready ? count[11:8] - 4'd1 : '0;
  assign AddressR  = (run && !count[12]) ? count[7:0] : '0;
endmodule

// File: tb/tb_me_control.sv
// tb_me_control: random-stimulus bench for me_control against a cycle-index model.
module tb_me_control;
  logic        clock = 0, reset = 1, start = 0;
  logic        busy, done, CompStart;
  logic [15:0] PEready, newDist;
  logic [3:0]  vectorX, vectorY;
  logic [7:0]  AddressR;

  me_control dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .CompStart(CompStart), .PEready(PEready), .vectorX(vectorX), .vectorY(vectorY),
    .newDist(newDist), .AddressR(AddressR)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // mc: -1 idle, 0..4111 cycle index within a search, 4112 the done cycle
  int mc = -1;
  bit armed = 0;
  always @(posedge clock) begin
    if (reset) begin
      mc = -1;
      armed = 1;
    end else if (mc == -1) mc = start ? 0 : -1;
    else if (mc == 4112) mc = -1;
    else mc++;
  end

  int pulses, uniq, nd_pulses, busy_cycles, low_run, searches;
  bit seen [256];
  bit prev_busy = 0;

  always @(negedge clock) if (armed) begin
    automatic bit run = mc >= 0 && mc <= 4111;
    automatic int row = mc / 256, off = mc % 256;
    automatic logic [15:0] e_nd = (run && mc < 4096 && off < 16) ? 16'(1 << off) : 16'h0;
    automatic bit rdy = run && row >= 1 && off < 16;
    chk("busy", busy, run);
    chk("done", done, mc == 4112);
    chk("compstart", CompStart, run);
    chk("newdist", newDist, e_nd);
    chk("peready", PEready, rdy ? 16'(1 << off) : 16'h0);
    chk("vectorx", vectorX, rdy ? off : 0);
    chk("vectory", vectorY, rdy ? row - 1 : 0);
    chk("addressr", AddressR, (run && mc < 4096) ? off : 0);
    if (mc == 0) begin
      chk("first_nd", newDist, 16'h0001);
      chk("first_pr", PEready, 16'h0000);
      pulses = 0; uniq = 0; nd_pulses = 0; busy_cycles = 0;
      foreach (seen[k]) seen[k] = 0;
    end
    if (mc == 259) begin
      chk("c259_pr", PEready, 16'h0008);
      chk("c259_nd", newDist, 16'h0008);
      chk("c259_vx", vectorX, 3);
      chk("c259_vy", vectorY, 0);
    end
    if (mc == 4111) begin
      chk("c4111_pr", PEready, 16'h8000);
      chk("c4111_nd", newDist, 16'h0000);
      chk("c4111_vx", vectorX, 15);
      chk("c4111_vy", vectorY, 15);
    end
    if (busy) busy_cycles++;
    if (newDist != 0) nd_pulses++;
    if (PEready != 0) begin
      pulses++;
      chk("onehot", $onehot(PEready), 1);
      if (!seen[{vectorY, vectorX}]) uniq++;
      seen[{vectorY, vectorX}] = 1;
    end
    if (mc == 4112) begin
      chk("sb_pulses", pulses, 256);
      chk("sb_unique", uniq, 256);
      chk("sb_newdist", nd_pulses, 256);
      chk("sb_busy", busy_cycles, 4112);
      chk("done_cs", CompStart, 0);
      searches++;
    end
    if (busy && !prev_busy && searches > 0) chk("gap", low_run >= 2, 1);
    low_run = busy ? 0 : low_run + 1;
    prev_busy = busy;
  end

  initial begin
    repeat (2) @(negedge clock);
    reset = 0;
    repeat (3) @(negedge clock);
    // single start pulse, start randomised (and ignored) while busy
    start = 1;
    @(negedge clock);
    start = 0;
    repeat (4125) begin
      @(negedge clock);
      start = (mc >= 0) ? 1'($urandom) : 1'b0;
    end
    start = 0;
    repeat (4) @(negedge clock);
    // start held high across two back-to-back searches
    start = 1;
    repeat (8240) @(negedge clock);
    start = 0;
    repeat (4) @(negedge clock);
    // abort mid-search
    start = 1;
    @(negedge clock);
    start = 0;
    for (int k = 0; k < 2000 && mc != 1000; k++) @(negedge clock);
    chk("reach1000", mc, 1000);
    reset = 1;
    @(negedge clock);
    reset = 0;
    chk("abort_idle", {busy, done, CompStart, PEready, newDist, vectorX, vectorY, AddressR}, 0);
    repeat (($urandom % 5) + 2) @(negedge clock);
    start = 1;
    @(negedge clock);
    start = 0;
    repeat (4125) begin
      @(negedge clock);
      start = (mc >= 0) ? 1'($urandom) : 1'b0;
    end
    start = 0;
    chk("searches", searches, 4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/me_control.md
ME_CONTROL -- requirements
Module: me_control

Interface
REQ-001 Parameters: none; the design is fixed at 16 PEs, 16x16 block, vector range 0..15.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; priority over all other inputs.
REQ-004 start  input  1  search request; sampled only in IDLE.
REQ-005 busy  output  1  high while a search is in progress (RUN state).
REQ-006 done  output  1  one-cycle pulse at search completion (DONE state).
REQ-007 CompStart  output  1  comparator enable; high in RUN; low in IDLE and DONE.
REQ-008 PEready  output  16  one-hot; bit i marks the cycle PE i's accumulated distance is valid for the comparator.
REQ-009 vectorX  output  4  X displacement paired with the asserted PEready bit.
REQ-010 vectorY  output  4  Y displacement paired with the asserted PEready bit.
REQ-011 newDist  output  16  one-hot; bit i tells PE i to clear its accumulator and load the first pixel difference.
REQ-012 AddressR  output  8  reference-block pixel address (row-major 16x16).

Function
REQ-013 States: IDLE, RUN, DONE; 13-bit cycle counter count.
REQ-014 IDLE: when start=1, go to RUN on the next edge with count=0; otherwise stay in IDLE.
REQ-015 RUN: count increments by 1 every cycle from 0 to 4111 inclusive; at count=4111 go to DONE next edge.
REQ-016 DONE: lasts exactly one cycle with done=1, then returns to IDLE; start is ignored in DONE.
REQ-017 start is ignored in RUN; there is no abort except reset.
REQ-018 All outputs are decoded from registered state/count; no combinational path from start to any output.
REQ-019 AddressR = count[7:0] while count<4096; 0 otherwise.
REQ-020 newDist[i]=1 iff RUN, count<4096, count[7:0]==i (i=0..15); all other cycles newDist=0.
REQ-021 PE i accumulates row y (y=0..15) over cycles 256*y+i .. 256*y+i+255 (staggered systolic start).
REQ-022 PEready[i]=1 iff RUN, count>=256, count[7:4]==0, count[3:0]==i; at most one bit high per cycle.
REQ-023 When PEready is nonzero: vectorX=count[3:0], vectorY=count[11:8]-1 (4-bit, count[12:8]=16 gives 15).
REQ-024 When PEready=0: vectorX=0, vectorY=0.
REQ-025 A complete search produces exactly 256 PEready pulses, one per (X,Y) pair, ordered Y-major, X-minor.
REQ-026 Overlap: at counts 256..4095 with low byte<16, newDist[i] and PEready[i] assert in the same cycle (PE i reports row y-1 while restarting for row y).
REQ-027 CompStart rises on the first RUN cycle and stays high through count=4111 inclusive.

Reset
REQ-028 On reset=1 at a rising edge: state=IDLE, count=0, and all outputs are 0 from the following cycle.
REQ-029 Reset mid-RUN abandons the search: no done pulse and no further PEready pulses until a new start.
REQ-030 If reset and start are both high at the same edge, the block remains in IDLE.

Verification
REQ-031 Reset held 2 cycles -> busy=0, done=0, CompStart=0, PEready=16'h0000, newDist=16'h0000, vectorX=vectorY=0.
REQ-032 Single start pulse in IDLE -> next cycle busy=1, CompStart=1, newDist=16'h0001, AddressR=0, PEready=0.
REQ-033 Run in progress -> at count=259: PEready=16'h0008, newDist=16'h0008, vectorX=3, vectorY=0; at count=4111: PEready=16'h8000, newDist=0, vectorX=15, vectorY=15; next cycle done=1, CompStart=0.
REQ-034 Full search with scoreboard -> exactly 256 PEready pulses, each one-hot, all 256 (vectorX,vectorY) pairs unique; 16*16 newDist pulses; total busy duration 4112 cycles.
REQ-035 start held high continuously -> the start asserted during RUN and DONE is ignored; a new search begins only from IDLE, so busy drops low for at least the DONE and IDLE cycles between back-to-back searches.
REQ-036 reset asserted at count=1000 -> next cycle IDLE with all outputs 0, no done pulse; a subsequent start runs a full 4112-cycle search normally.
